// File: rtl/i2s_tx.sv
// Purpose: standard I2S transmitter; BCLK = clk_in/4, LRCLK = clk_in/256, MSB one BCLK after each LRCLK edge.
// Latency: samples captured on the frame-start edge (cnt=0) are serialised during that same 256-cycle frame.
// Backpressure: none; free-running, inputs sampled once per frame. Optional mute input under `I2S_TX_MUTE_EN`.
`timescale 1ns/1ps
module i2s_tx #(
   parameter int WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] sample_l,
   input  logic [WIDTH-1:0] sample_r,
`ifdef I2S_TX_MUTE_EN
   input  logic             mute_in,
`endif
   output logic             bclk_out,
   output logic             lrclk_out,
   output logic             sdata_out,
   output logic             frame_strobe_out
);

   // Frame position and its successor; every output is computed from the
   // successor so the registered outputs line up with the loaded count.
   logic [7:0]       cnt;
   logic [7:0]       cnt_nxt;
   logic             frame_start;

   // Per-channel words held for the whole frame.
   logic [WIDTH-1:0] shadow_l;
   logic [WIDTH-1:0] shadow_r;
   logic [WIDTH-1:0] cap_l;
   logic [WIDTH-1:0] cap_r;

   // Serialiser selection for the upcoming count.
   logic [4:0]       slot_nxt;
   logic [WIDTH-1:0] word_nxt;
   logic             sdata_nxt;

   // Next count and frame-start detection (wrap 255 -> 0).
   always_comb begin
      cnt_nxt     = cnt + 8'd1;
      frame_start = (cnt_nxt == 8'd0);
   end

   // Values presented to the shadow registers at the capture edge.
   always_comb begin
`ifdef I2S_TX_MUTE_EN
      cap_l = mute_in ? '0 : sample_l;
      cap_r = mute_in ? '0 : sample_r;
`else
      cap_l = sample_l;
      cap_r = sample_r;
`endif
   end

   // Pick the bit for the next slot: slot s (1..WIDTH) carries word bit WIDTH-s,
   // slot 0 and slots beyond WIDTH are idle low (no sign extension).
   always_comb begin
      slot_nxt  = cnt_nxt[6:2];
      word_nxt  = cnt_nxt[7] ? shadow_r : shadow_l;
      sdata_nxt = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (slot_nxt == 5'(WIDTH - i)) begin
            sdata_nxt = word_nxt[i];
         end
      end
   end

   // Free-running frame counter; reset parks it at 255 so release starts a frame.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt <= 8'hFF;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   // Capture both channels only on the edge that starts a frame.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         shadow_l <= '0;
         shadow_r <= '0;
      end else if (frame_start) begin
         shadow_l <= cap_l;
         shadow_r <= cap_r;
      end
   end

   // Registered serial outputs; sdata and lrclk only move when cnt[1:0] wraps to 0.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bclk_out         <= 1'b0;
         lrclk_out        <= 1'b0;
         sdata_out        <= 1'b0;
         frame_strobe_out <= 1'b0;
      end else begin
         bclk_out         <= cnt_nxt[1];
         lrclk_out        <= cnt_nxt[7];
         sdata_out        <= sdata_nxt;
         frame_strobe_out <= frame_start;
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: randomized frames against a frame-level reference model.
// Driver queues the expected captured words per frame; monitor checks every cycle.
// Covers reset, capture timing, MSB placement, mid-frame input change, mid-frame reset, optional mute.
`timescale 1ns/1ps
module tb_i2s_tx;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] l;
      logic [W-1:0] r;
   } frame_t;

   logic         clk_in = 1'b0;
   logic         rst_in = 1'b1;
   logic [W-1:0] sample_l = '0;
   logic [W-1:0] sample_r = '0;
`ifdef I2S_TX_MUTE_EN
   logic         mute_in = 1'b0;
`endif
   logic         bclk_out;
   logic         lrclk_out;
   logic         sdata_out;
   logic         frame_strobe_out;

   frame_t exp_q[$];
   int     n_vec  = 0;
   int     n_fail = 0;

   i2s_tx #(.WIDTH(W)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .sample_l         (sample_l),
      .sample_r         (sample_r),
`ifdef I2S_TX_MUTE_EN
      .mute_in          (mute_in),
`endif
      .bclk_out         (bclk_out),
      .lrclk_out        (lrclk_out),
      .sdata_out        (sdata_out),
      .frame_strobe_out (frame_strobe_out)
   );

   always #5 clk_in = ~clk_in;

   // Monitor: tracks the frame position from reset history alone, pops the
   // expected words at each frame start and checks all outputs mid-cycle.
   initial begin : monitor
      int           m;
      bit           r;
      int           slot;
      frame_t       cur;
      logic [W-1:0] w;
      logic [3:0]   need;
      logic [3:0]   got;
      m   = 255;
      cur = '0;
      forever begin
         @(posedge clk_in);
         r = rst_in;
         m = r ? 255 : (m + 1) % 256;
         @(negedge clk_in);
         if (!r && m == 0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL frame_pop: expectation queue empty at frame start, need one queued frame");
               cur = '0;
            end else begin
               cur = exp_q.pop_front();
            end
         end
         if (r) begin
            need = 4'b0000;
         end else begin
            slot    = (m % 128) / 4;
            w       = (m >= 128) ? cur.r : cur.l;
            need[3] = (m == 0);
            need[2] = ((m % 4) >= 2);
            need[1] = (m >= 128);
            need[0] = (slot >= 1 && slot <= W) ? w[W - slot] : 1'b0;
         end
         got = {frame_strobe_out, bclk_out, lrclk_out, sdata_out};
         n_vec++;
         if (got !== need) begin
            n_fail++;
            $display("FAIL outputs t=%0t cnt=%0d rst=%0d: strobe/bclk/lrclk/sdata got %b need %b",
                     $time, m, r, got, need);
         end
      end
   end

   // Drive one frame starting at the next edge; optionally scramble inputs at
   // cnt=100 or assert reset at cnt=abort_at (then hold it for three edges).
   task automatic do_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                           input bit mute, input bit chg, input int abort_at);
      frame_t e;
      rst_in   = 1'b0;
      sample_l = l;
      sample_r = r;
`ifdef I2S_TX_MUTE_EN
      mute_in  = mute;
      e = mute ? '0 : '{l: l, r: r};
`else
      e = '{l: l, r: r};
`endif
      exp_q.push_back(e);
      @(posedge clk_in); #1;
      for (int c = 1; c < 256; c++) begin
         @(posedge clk_in); #1;
         if (chg && c == 100) begin
            sample_l = W'($urandom);
            sample_r = W'($urandom);
`ifdef I2S_TX_MUTE_EN
            mute_in  = ~mute_in;
`endif
         end
         if (abort_at != 0 && c == abort_at) begin
            rst_in = 1'b1;
            repeat (3) begin
               @(posedge clk_in); #1;
            end
            return;
         end
      end
   endtask

   // Stimulus sequence.
   initial begin : driver
      repeat (4) @(posedge clk_in);
      #1;
      do_frame(16'hA5C3, 16'h0001, 1'b0, 1'b0, 0);
      do_frame(16'h8000, W'($urandom), 1'b0, 1'b0, 0);
      do_frame(W'($urandom), W'($urandom), 1'b0, 1'b1, 0);
      do_frame(W'($urandom), W'($urandom), 1'b0, 1'b0, 0);
      do_frame(W'($urandom), W'($urandom), 1'b0, 1'b0, 150);
      do_frame(W'($urandom), W'($urandom), 1'b0, 1'b1, 0);
      do_frame(16'h7FFF, 16'h8000, 1'b0, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         do_frame(W'($urandom), W'($urandom), 1'b0, k[0], 0);
      end
`ifdef I2S_TX_MUTE_EN
      do_frame(16'h7FFF, W'($urandom), 1'b1, 1'b0, 0);
      do_frame(16'h7FFF, W'($urandom), 1'b0, 1'b1, 0);
`endif
      rst_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
